// File: rtl/relay_sequencer_fsm.sv
// relay_sequencer_fsm
// ---------------------------------------------------------------------------
// Instruction sequencer for the relay computer. It walks a one-hot state
// vector through fetch (S1..S3), the class sample in S4, the common
// PC-increment phase (S5..S7) and the class-specific tail of each
// instruction (S8..S24). Each state is held for TICKS_PER_STATE clocks to
// emulate relay settle time. A HALT request on the final tick of an
// instruction parks the machine in HALTED until reset.
//
// Optional feature macro: RELAY_SEQ_SINGLE_STEP_EN
//   When defined, adds step_mode/step inputs. With step_mode=1 a state only
//   ends on its final tick when step=1.
//
// Parameters
//   TICKS_PER_STATE  clocks each state is held (1..255)
// Ports
//   clk          system clock
//   reset        synchronous active-high reset
//   run          leave IDLE and start fetching (ignored elsewhere)
//   fsm_input    instruction class from decode, sampled on S4's final tick
//   halt         HALT request, honoured only at instruction end
//   step_mode    (macro only) enable single-step gating
//   step         (macro only) advance permission while step_mode=1
//   state_vec    one-hot state, bit n-1 = S<n>, zero in IDLE/HALTED
//   busy         high in S1..S24
//   halted       high in HALTED
//   instr_done   pulse on the final tick of an instruction's last state
//   err_illegal  sticky, set when an illegal class is captured
// ---------------------------------------------------------------------------
module relay_sequencer_fsm #(
  parameter int TICKS_PER_STATE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [3:0]  fsm_input,
  input  logic        halt,
`ifdef RELAY_SEQ_SINGLE_STEP_EN
  input  logic        step_mode,
  input  logic        step,
`endif
  output logic [23:0] state_vec,
  output logic        busy,
  output logic        halted,
  output logic        instr_done,
  output logic        err_illegal
);

  // State encoding: IDLE=0, S1..S24 = 1..24, HALTED=25.
  localparam logic [4:0] ST_IDLE   = 5'd0;
  localparam logic [4:0] ST_S1     = 5'd1;
  localparam logic [4:0] ST_S4     = 5'd4;
  localparam logic [4:0] ST_S7     = 5'd7;
  localparam logic [4:0] ST_S10    = 5'd10;
  localparam logic [4:0] ST_S11    = 5'd11;
  localparam logic [4:0] ST_S13    = 5'd13;
  localparam logic [4:0] ST_S24    = 5'd24;
  localparam logic [4:0] ST_HALTED = 5'd25;

  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_STATE - 1);

  // Classes that the decode logic is allowed to return.
  function automatic logic cls_legal(input logic [3:0] c);
    logic ok;
    case (c)
      4'b0000, 4'b0100, 4'b1000,
      4'b1001, 4'b1010, 4'b1011,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Last state of an instruction for a given class; illegal classes end at S7.
  function automatic logic [4:0] last_state(input logic [3:0] c);
    logic [4:0] ls;
    case (c)
      4'b1001:                            ls = ST_S11;
      4'b1010:                            ls = ST_S10;
      4'b1011:                            ls = ST_S13;
      4'b1100, 4'b1101, 4'b1110, 4'b1111: ls = ST_S24;
      default:                            ls = ST_S7;
    endcase
    return ls;
  endfunction

  logic [4:0] state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [3:0] cls_q, cls_d;
  logic       err_q, err_d;

  logic busy_s;
  logic tick_done_s;
  logic step_ok_s;
  logic final_tick_s;
  logic end_s;

`ifdef RELAY_SEQ_SINGLE_STEP_EN
  assign step_ok_s = ~step_mode | step;
`else
  assign step_ok_s = 1'b1;
`endif

  assign busy_s       = (state_q >= ST_S1) && (state_q <= ST_S24);
  assign tick_done_s  = (tick_q == TICK_LAST);
  // In step mode the counter parks on its last value until step arrives.
  assign final_tick_s = busy_s & tick_done_s & step_ok_s;
  assign end_s        = final_tick_s & (state_q == last_state(cls_q));

  // Next-state, tick counter, class capture and sticky error logic.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    cls_d   = cls_q;
    err_d   = err_q;
    if (busy_s) begin
      if (final_tick_s) begin
        tick_d = 8'd0;
        if (end_s) begin
          if (halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_S1;
          end
        end else begin
          state_d = state_q + 5'd1;
        end
        if (state_q == ST_S4) begin
          cls_d = fsm_input;
          if (!cls_legal(fsm_input)) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
        end else begin
          cls_d = cls_q;
        end
      end else if (!tick_done_s) begin
        tick_d = tick_q + 8'd1;
      end else begin
        tick_d = tick_q;
      end
    end else if (state_q == ST_IDLE) begin
      tick_d = 8'd0;
      if (run) begin
        state_d = ST_S1;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_HALTED) begin
      tick_d  = 8'd0;
      state_d = ST_HALTED;
    end else begin
      // Unused encodings recover to IDLE.
      tick_d  = 8'd0;
      state_d = ST_IDLE;
    end
  end

  // State, counter, class and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tick_q  <= 8'd0;
      cls_q   <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
    end
  end

  // One-hot decode of the state register; zero outside S1..S24.
  always_comb begin
    state_vec = 24'd0;
    if (busy_s) begin
      state_vec = 24'd1 << (state_q - 5'd1);
    end else begin
      state_vec = 24'd0;
    end
  end

  assign busy        = busy_s;
  assign halted      = (state_q == ST_HALTED);
  // A pending reset cancels the instruction end, so no pulse is shown.
  assign instr_done  = end_s & ~reset;
  assign err_illegal = err_q;

endmodule

// File: tb/tb_relay_sequencer_fsm.sv
// Self-checking bench for relay_sequencer_fsm. Two instances: dut_a with
// TICKS_PER_STATE=1 and dut_b with TICKS_PER_STATE=2. Expected per-cycle
// state vectors and instr_done values are pushed to a scoreboard queue when
// an instruction is started and popped/compared as the DUT steps.
module tb_relay_sequencer_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, run_a, halt_a;
  logic [3:0]  fin_a;
  logic [23:0] sv_a;
  logic        busy_a, halted_a, done_a, err_a;

  logic        rst_b, run_b, halt_b;
  logic [3:0]  fin_b;
  logic [23:0] sv_b;
  logic        busy_b, halted_b, done_b, err_b;

`ifdef RELAY_SEQ_SINGLE_STEP_EN
  logic smode_a, step_a, smode_b, step_b;
`endif

  relay_sequencer_fsm #(.TICKS_PER_STATE(1)) dut_a (
    .clk(clk), .reset(rst_a), .run(run_a), .fsm_input(fin_a), .halt(halt_a),
`ifdef RELAY_SEQ_SINGLE_STEP_EN
    .step_mode(smode_a), .step(step_a),
`endif
    .state_vec(sv_a), .busy(busy_a), .halted(halted_a),
    .instr_done(done_a), .err_illegal(err_a)
  );

  relay_sequencer_fsm #(.TICKS_PER_STATE(2)) dut_b (
    .clk(clk), .reset(rst_b), .run(run_b), .fsm_input(fin_b), .halt(halt_b),
`ifdef RELAY_SEQ_SINGLE_STEP_EN
    .step_mode(smode_b), .step(step_b),
`endif
    .state_vec(sv_b), .busy(busy_b), .halted(halted_b),
    .instr_done(done_b), .err_illegal(err_b)
  );

  typedef struct packed {
    logic [23:0] vec;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] sv_of(input int d);
    return (d == 0) ? sv_a : sv_b;
  endfunction
  function automatic logic done_of(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction
  function automatic logic busy_of(input int d);
    return (d == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic halted_of(input int d);
    return (d == 0) ? halted_a : halted_b;
  endfunction
  function automatic logic err_of(input int d);
    return (d == 0) ? err_a : err_b;
  endfunction

  // Number of states an instruction of class c occupies.
  function automatic int last_of(input logic [3:0] c);
    if (c == 4'b1001) return 11;
    if (c == 4'b1010) return 10;
    if (c == 4'b1011) return 13;
    if (c[3:2] == 2'b11) return 24;
    return 7;
  endfunction

  // Push expected cycles for states S1..S<nstates> of a class-c instruction.
  task automatic push_instr(input int t, input logic [3:0] c, input int nstates);
    int last;
    last = last_of(c);
    for (int s = 1; s <= nstates; s++) begin
      for (int k = 0; k < t; k++) begin
        exp_t e;
        e.vec  = 24'd1 << (s - 1);
        e.done = (s == last) && (k == t - 1);
        sb_q.push_back(e);
      end
    end
  endtask

  // Compare n scoreboard entries against dut d, one clock each.
  task automatic pop_n(input int d, input int n, input string tag, output logic seen24);
    logic [23:0] v;
    seen24 = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s: scoreboard empty observed %0d expected %0d", tag, 0, 1);
      end else begin
        e = sb_q.pop_front();
        v = sv_of(d);
        chk({tag, "_vec"},  32'(v), 32'(e.vec));
        chk({tag, "_done"}, 32'(done_of(d)), 32'(e.done));
        chk({tag, "_busy"}, 32'(busy_of(d)), 32'd1);
        if (v[23]) seen24 = 1'b1;
      end
      tick();
    end
  endtask

  task automatic check_idle(input int d, input string tag, input logic exp_err);
    chk({tag, "_vec"},    32'(sv_of(d)),     32'd0);
    chk({tag, "_busy"},   32'(busy_of(d)),   32'd0);
    chk({tag, "_halted"}, 32'(halted_of(d)), 32'd0);
    chk({tag, "_done"},   32'(done_of(d)),   32'd0);
    chk({tag, "_err"},    32'(err_of(d)),    32'(exp_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic s24;
    rst_a = 1'b1; run_a = 1'b0; halt_a = 1'b0; fin_a = 4'b0000;
    rst_b = 1'b1; run_b = 1'b0; halt_b = 1'b0; fin_b = 4'b0000;
`ifdef RELAY_SEQ_SINGLE_STEP_EN
    smode_a = 1'b0; step_a = 1'b0; smode_b = 1'b0; step_b = 1'b0;
`endif
    tick(); tick();
    check_idle(0, "rst_a", 1'b0);
    check_idle(1, "rst_b", 1'b0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();
    check_idle(0, "idle_a", 1'b0);

    // MOV-8 at T=1 with a one-clock run pulse; then the next S1.
    fin_a = 4'b0000;
    run_a = 1'b1; tick(); run_a = 1'b0;
    push_instr(1, 4'b0000, 7);
    push_instr(1, 4'b0000, 1);
    pop_n(0, 8, "mov8", s24);

    // Class lengths at T=2: 22, 26 and 48 clocks.
    fin_b = 4'b1001;
    run_b = 1'b1; tick(); run_b = 1'b0;
    push_instr(2, 4'b1001, 11);
    pop_n(1, 22, "ldst", s24);
    chk("ldst_no_s24", 32'(s24), 32'd0);
    fin_b = 4'b1011;
    push_instr(2, 4'b1011, 13);
    pop_n(1, 26, "inc", s24);
    chk("inc_no_s24", 32'(s24), 32'd0);
    fin_b = 4'b1100;
    push_instr(2, 4'b1100, 24);
    pop_n(1, 48, "goto", s24);
    chk("goto_s24", 32'(s24), 32'd1);

    // HALT: class 1010 with halt raised from S9.
    fin_b = 4'b1010;
    push_instr(2, 4'b1010, 10);
    pop_n(1, 16, "mov16", s24);
    halt_b = 1'b1;
    pop_n(1, 4, "mov16_end", s24);
    chk("halt_vec",    32'(sv_b),     32'd0);
    chk("halt_halted", 32'(halted_b), 32'd1);
    chk("halt_busy",   32'(busy_b),   32'd0);
    run_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_run_ign", 32'(halted_b), 32'd1);
      chk("halt_run_vec", 32'(sv_b),     32'd0);
    end
    run_b = 1'b0; halt_b = 1'b0;
    rst_b = 1'b1; tick(); rst_b = 1'b0;
    check_idle(1, "halt_rst", 1'b0);

    // Reset during S15 of a GOTO.
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    fin_a = 4'b1100;
    run_a = 1'b1; tick(); run_a = 1'b0;
    push_instr(1, 4'b1100, 14);
    pop_n(0, 14, "goto_a", s24);
    chk("s15_vec",  32'(sv_a),   32'h004000);
    chk("s15_done", 32'(done_a), 32'd0);
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    check_idle(0, "mid_rst", 1'b0);

    // Illegal class: flag set, ends after S7, sticky until reset.
    fin_a = 4'b0110;
    run_a = 1'b1; tick(); run_a = 1'b0;
    push_instr(1, 4'b0110, 7);
    pop_n(0, 7, "illegal", s24);
    chk("ill_err_set", 32'(err_a), 32'd1);
    fin_a = 4'b1001;
    push_instr(1, 4'b1001, 11);
    pop_n(0, 11, "after_ill", s24);
    chk("ill_err_sticky", 32'(err_a), 32'd1);
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    check_idle(0, "ill_rst", 1'b0);

`ifdef RELAY_SEQ_SINGLE_STEP_EN
    // Single step: S3 held without step, one pulse advances exactly once.
    smode_a = 1'b1; step_a = 1'b0; fin_a = 4'b0000;
    run_a = 1'b1; tick(); run_a = 1'b0;
    chk("ss_s1", 32'(sv_a), 32'h000001);
    step_a = 1'b1; tick(); step_a = 1'b0;
    chk("ss_s2", 32'(sv_a), 32'h000002);
    step_a = 1'b1; tick(); step_a = 1'b0;
    chk("ss_s3", 32'(sv_a), 32'h000004);
    for (int i = 0; i < 50; i++) begin
      tick();
    end
    chk("ss_s3_held", 32'(sv_a), 32'h000004);
    step_a = 1'b1; tick(); step_a = 1'b0;
    chk("ss_s4", 32'(sv_a), 32'h000008);
    for (int i = 0; i < 5; i++) begin
      tick();
    end
    chk("ss_s4_held", 32'(sv_a), 32'h000008);
    smode_a = 1'b0;
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
